tlb_srch_arb: RTL and testbench

TLB_SRCH_ARB -- requirements
Module: tlb_srch_arb

---
 rtl/tlb_srch_arb.sv | 140 ++++++++++++++
 tb/tb_tlb_srch_arb.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tlb_srch_arb.sv
// Round-robin arbiter sharing one TLB search port between fetch (0) and data (1) requesters.
// Latency: accept N, s_valid N+1, s_match sampled N+2, rsp_valid N+3; rsp held until rsp_ready.
// Backpressure: one search in flight, no accept outside IDLE. Optional TLB_MULTIHIT_CHK_EN adds rsp_mhit.
module tlb_srch_arb #(
    parameter int VPPN_W = 19,
    parameter int ASID_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [VPPN_W-1:0] req0_vppn,
    input  logic [ASID_W-1:0] req0_asid,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [VPPN_W-1:0] req1_vppn,
    input  logic [ASID_W-1:0] req1_asid,
    output logic              s_valid,
    output logic [VPPN_W-1:0] s_vppn,
    output logic [ASID_W-1:0] s_asid,
    input  logic [31:0]       s_match,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic              rsp_hit,
    output logic [4:0]        rsp_idx,
    output logic              rsp_mhit,
    input  logic              flush
);

    typedef enum logic [1:0] {IDLE, SRCH, WAIT, RESP} state_t;

    state_t            state_q;
    logic              ptr_q;
    logic [VPPN_W-1:0] vppn_q;
    logic [ASID_W-1:0] asid_q;
    logic              id_q;
    logic              s_valid_q;
    logic              rsp_valid_q;
    logic              rsp_hit_q;
    logic [4:0]        rsp_idx_q;

    logic              any_vld;
    logic              gnt_id;
    logic              accept;
    logic              hit_d;
    logic [4:0]        idx_d;

    // ptr_q names the requester that wins when both are valid.
    always_comb begin
        any_vld    = req0_valid | req1_valid;
        gnt_id     = (req0_valid && req1_valid) ? ptr_q : req1_valid;
        accept     = (state_q == IDLE) && !flush && !reset && any_vld;
        req0_ready = accept && !gnt_id;
        req1_ready = accept && gnt_id;
    end

    always_comb begin
        hit_d = |s_match;
        idx_d = 5'd0;
        for (int i = 31; i >= 0; i--) begin
            if (s_match[i]) idx_d = 5'(i);
        end
    end

`ifdef TLB_MULTIHIT_CHK_EN
    logic mhit_d;
    logic rsp_mhit_q;

    // Clearing the lowest set bit leaves something only if two or more were set.
    always_comb mhit_d = |(s_match & (s_match - 32'd1));
    assign rsp_mhit = rsp_mhit_q;
`else
    assign rsp_mhit = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            ptr_q       <= 1'b0;
            vppn_q      <= '0;
            asid_q      <= '0;
            id_q        <= 1'b0;
            s_valid_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_hit_q   <= 1'b0;
            rsp_idx_q   <= 5'd0;
`ifdef TLB_MULTIHIT_CHK_EN
            rsp_mhit_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        vppn_q    <= gnt_id ? req1_vppn : req0_vppn;
                        asid_q    <= gnt_id ? req1_asid : req0_asid;
                        id_q      <= gnt_id;
                        ptr_q     <= ~gnt_id;
                        s_valid_q <= 1'b1;
                        state_q   <= SRCH;
                    end
                end
                SRCH: begin
                    s_valid_q <= 1'b0;
                    state_q   <= flush ? IDLE : WAIT;
                end
                WAIT: begin
                    if (flush) begin
                        state_q <= IDLE;
                    end else begin
                        rsp_hit_q   <= hit_d;
                        rsp_idx_q   <= idx_d;
`ifdef TLB_MULTIHIT_CHK_EN
                        rsp_mhit_q  <= mhit_d;
`endif
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end
                end
                RESP: begin
                    // A flush coinciding with rsp_ready still completes the handshake.
                    if (flush || rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign s_valid   = s_valid_q;
    assign s_vppn    = vppn_q;
    assign s_asid    = asid_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = id_q;
    assign rsp_hit   = rsp_hit_q;
    assign rsp_idx   = rsp_idx_q;

endmodule

// File: tb/tb_tlb_srch_arb.sv
// Self-checking bench for tlb_srch_arb: vector table plus contention, flush and reset sequences.
// Expected responses are queued when a search is planned and popped at each response handshake.
module tb_tlb_srch_arb;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [18:0] req0_vppn = '0, req1_vppn = '0;
    logic [9:0]  req0_asid = '0, req1_asid = '0;
    logic        s_valid;
    logic [18:0] s_vppn;
    logic [9:0]  s_asid;
    logic [31:0] s_match = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic        rsp_id, rsp_hit, rsp_mhit;
    logic [4:0]  rsp_idx;
    logic        flush = 1'b0;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        id;
        logic [18:0] vppn;
        logic [9:0]  asid;
        logic [31:0] match;
        logic        hit;
        logic [4:0]  idx;
        logic        mhit;
        logic        fl;
    } vec_t;

    typedef struct {
        logic       id;
        logic       hit;
        logic [4:0] idx;
        logic       mhit;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] mq[$];
    logic        gnt_log[$];
    vec_t        vecs[7];

    tlb_srch_arb #(.VPPN_W(19), .ASID_W(10)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_vppn(req0_vppn), .req0_asid(req0_asid),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_vppn(req1_vppn), .req1_asid(req1_asid),
        .s_valid(s_valid), .s_vppn(s_vppn), .s_asid(s_asid), .s_match(s_match),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_hit(rsp_hit),
        .rsp_idx(rsp_idx), .rsp_mhit(rsp_mhit), .flush(flush)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic exp_mhit(input logic m);
`ifdef TLB_MULTIHIT_CHK_EN
        return m;
`else
        return 1'b0 & m;
`endif
    endfunction

    task automatic plan(input logic id, input logic [31:0] m, input logic hit,
                        input logic [4:0] idx, input logic mh);
        exp_t e;
        e.id = id; e.hit = hit; e.idx = idx; e.mhit = exp_mhit(mh);
        mq.push_back(m);
        exp_q.push_back(e);
    endtask

    // TLB model: present the planned match vector for the cycle after s_valid, noise otherwise.
    initial begin
        int hold = 0;
        forever begin
            @(negedge clk);
            if (reset) hold = 0;
            if (hold > 0) hold--;
            else s_match = $urandom;
            if (s_valid) begin
                s_match = 32'h0;
                if (mq.size() > 0) s_match = mq.pop_front();
                hold = 1;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!reset && req0_valid && req0_ready) gnt_log.push_back(1'b0);
            if (!reset && req1_valid && req1_ready) gnt_log.push_back(1'b1);
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    chk("rsp_unexpected", rsp_valid, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("rsp_id", rsp_id, e.id);
                    chk("rsp_hit", rsp_hit, e.hit);
                    chk("rsp_idx", rsp_idx, e.idx);
                    chk("rsp_mhit", rsp_mhit, e.mhit);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic check_zero(input string tag);
        chk({tag, "_s_valid"}, s_valid, 0);
        chk({tag, "_s_vppn"}, s_vppn, 0);
        chk({tag, "_s_asid"}, s_asid, 0);
        chk({tag, "_rsp_valid"}, rsp_valid, 0);
        chk({tag, "_rsp_id"}, rsp_id, 0);
        chk({tag, "_rsp_hit"}, rsp_hit, 0);
        chk({tag, "_rsp_idx"}, rsp_idx, 0);
        chk({tag, "_rsp_mhit"}, rsp_mhit, 0);
        chk({tag, "_req0_ready"}, req0_ready, 0);
        chk({tag, "_req1_ready"}, req1_ready, 0);
    endtask

    task automatic wait_rsp();
        int n = 0;
        @(negedge clk);
        while (rsp_valid !== 1'b1 && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("rsp_wait", rsp_valid, 1);
    endtask

    task automatic ack();
        @(posedge clk); #1 rsp_ready = 1'b1;
        @(posedge clk); #1 rsp_ready = 1'b0;
    endtask

    task automatic reset_pulse();
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        int n = 0;
        plan(v.id, v.match, v.hit, v.idx, v.mhit);
        @(posedge clk); #1;
        if (v.id) begin req1_valid = 1'b1; req1_vppn = v.vppn; req1_asid = v.asid; end
        else      begin req0_valid = 1'b1; req0_vppn = v.vppn; req0_asid = v.asid; end
        @(negedge clk);
        while ((v.id ? req1_ready : req0_ready) !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("accept", 32'(n < 20), 1);
        @(posedge clk); #1 req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
        chk("s_valid_n1", s_valid, 1);
        chk("s_vppn", s_vppn, v.vppn);
        chk("s_asid", s_asid, v.asid);
        @(negedge clk);
        chk("s_valid_n2", s_valid, 0);
        chk("rsp_early", rsp_valid, 0);
        @(negedge clk);
        chk("rsp_n3", rsp_valid, 1);
        @(posedge clk); #1 rsp_ready = 1'b1; flush = v.fl;
        @(posedge clk); #1 rsp_ready = 1'b0; flush = 1'b0;
        @(negedge clk);
        chk("rsp_done", rsp_valid, 0);
    endtask

    initial begin
        logic       cap_id, cap_hit;
        logic [4:0] cap_idx;

        vecs[0] = '{1'b0, 19'h12345, 10'h03A, 32'h0000_0100, 1'b1, 5'd8,  1'b0, 1'b0};
        vecs[1] = '{1'b1, 19'h7FFFF, 10'h3FF, 32'h0000_0000, 1'b0, 5'd0,  1'b0, 1'b0};
        vecs[2] = '{1'b0, 19'h00001, 10'h001, 32'h8000_0006, 1'b1, 5'd1,  1'b1, 1'b0};
        vecs[3] = '{1'b1, 19'h2AAAA, 10'h155, 32'h8000_0000, 1'b1, 5'd31, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 19'h55555, 10'h2AA, 32'h0000_0001, 1'b1, 5'd0,  1'b0, 1'b1};
        vecs[5] = '{1'b1, 19'h00000, 10'h000, 32'hFFFF_FFFF, 1'b1, 5'd0,  1'b1, 1'b0};
        vecs[6] = '{1'b0, 19'h3C3C3, 10'h0F0, 32'h0001_0100, 1'b1, 5'd8,  1'b1, 1'b0};

        #12 req0_valid = 1'b1; req1_valid = 1'b1;
        #1 check_zero("rst");
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(posedge clk); #1 reset = 1'b0;

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // Contention from reset, with long backpressure on the first response.
        reset_pulse();
        gnt_log.delete();
        plan(1'b0, 32'h0000_0004, 1'b1, 5'd2,  1'b0);
        plan(1'b1, 32'h0000_0000, 1'b0, 5'd0,  1'b0);
        plan(1'b0, 32'h0000_0030, 1'b1, 5'd4,  1'b1);
        plan(1'b1, 32'h4000_0000, 1'b1, 5'd30, 1'b0);
        @(posedge clk); #1;
        req0_valid = 1'b1; req0_vppn = 19'h11111; req0_asid = 10'h001;
        req1_valid = 1'b1; req1_vppn = 19'h22222; req1_asid = 10'h002;
        for (int k = 0; k < 4; k++) begin
            wait_rsp();
            if (k == 0) begin
                cap_id = rsp_id; cap_hit = rsp_hit; cap_idx = rsp_idx;
                repeat (5) begin
                    @(negedge clk);
                    chk("bp_valid", rsp_valid, 1);
                    chk("bp_id", rsp_id, cap_id);
                    chk("bp_hit", rsp_hit, cap_hit);
                    chk("bp_idx", rsp_idx, cap_idx);
                    chk("bp_rdy", {req0_ready, req1_ready}, 2'b00);
                end
            end
            @(posedge clk); #1 rsp_ready = 1'b1;
            if (k == 3) begin req0_valid = 1'b0; req1_valid = 1'b0; end
            @(posedge clk); #1 rsp_ready = 1'b0;
        end
        chk("gnt_cnt", gnt_log.size(), 4);
        for (int j = 0; j < 4; j++)
            chk("gnt_order", (j < gnt_log.size()) ? 32'(gnt_log[j]) : 32'hFFFF, 32'(j % 2));

        // Flush in IDLE blocks acceptance.
        @(posedge clk); #1 flush = 1'b1; req0_valid = 1'b1;
        @(negedge clk);
        chk("flush_idle_rdy", req0_ready, 0);
        @(posedge clk); #1 flush = 1'b0; req0_valid = 1'b0;

        // Flush in WAIT: no response, pointer still advanced by the flushed grant.
        mq.push_back(32'h0000_0F00);
        @(posedge clk); #1 req0_valid = 1'b1; req1_valid = 1'b1;
        @(negedge clk);
        chk("fl_gnt", {req0_ready, req1_ready}, 2'b10);
        @(posedge clk); #1 req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
        chk("fl_s_valid", s_valid, 1);
        @(posedge clk); #1 flush = 1'b1;
        @(negedge clk);
        chk("fl_wait_rsp", rsp_valid, 0);
        plan(1'b1, 32'h0000_0200, 1'b1, 5'd9, 1'b0);
        @(posedge clk); #1 flush = 1'b0; req0_valid = 1'b1; req1_valid = 1'b1;
        @(negedge clk);
        chk("fl_no_rsp", rsp_valid, 0);
        chk("fl_rr_adv", {req0_ready, req1_ready}, 2'b01);
        @(posedge clk); #1 req0_valid = 1'b0; req1_valid = 1'b0;
        wait_rsp();
        ack();

        // Reset while a response is pending.
        mq.push_back(32'h8000_0010);
        @(posedge clk); #1 req0_valid = 1'b1; req0_vppn = 19'h7ABCD; req0_asid = 10'h3FF;
        @(posedge clk); #1 req0_valid = 1'b0;
        wait_rsp();
        chk("pre_rst_idx", rsp_idx, 4);
        #1 reset = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1;
        #1 check_zero("rst_resp");
        @(posedge clk); #1 req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("post_rst_no_rsp", rsp_valid, 0);
        end
        rsp_ready = 1'b0;
        plan(1'b0, 32'h0000_0002, 1'b1, 5'd1, 1'b0);
        @(posedge clk); #1 req0_valid = 1'b1; req1_valid = 1'b1;
        @(negedge clk);
        chk("post_rst_gnt", {req0_ready, req1_ready}, 2'b10);
        @(posedge clk); #1 req0_valid = 1'b0; req1_valid = 1'b0;
        wait_rsp();
        ack();

        repeat (3) @(negedge clk);
        chk("sb_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
